// File: rtl/bitrev_reorder_buf_if.sv
// bitrev_reorder_buf_if: input and output stream handshakes of the bit-reverse reorder buffer
interface bitrev_reorder_buf_if #(
   parameter int DATA_W = 64
);
   logic [2:0]        frame_log;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   modport master (
      output frame_log, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
   modport slave (
      input  frame_log, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/bitrev_reorder_buf.sv
// bitrev_reorder_buf: ping-pong buffer turning bit-reversed coefficient frames into natural order
module bitrev_reorder_buf #(
   parameter int DATA_W    = 64,
   parameter int LOG_N_MAX = 6
) (
   input logic                 clk,
   input logic                 rst,
   bitrev_reorder_buf_if.slave io_s
);
   localparam int                   FW    = $clog2(LOG_N_MAX + 1);
   localparam int                   N_MAX = 1 << LOG_N_MAX;
   localparam logic [FW-1:0]        L_MAX = FW'(LOG_N_MAX);
   localparam logic [LOG_N_MAX-1:0] ONES  = '1;
   logic [DATA_W-1:0]    r_mem [2][N_MAX];
   logic [1:0]           r_full;
   logic [FW-1:0]        r_flog [2];
   logic                 r_wr_sel, r_rd_sel;
   logic [LOG_N_MAX-1:0] r_wr_cnt, r_rd_cnt;
   logic [FW-1:0]        w_flog_in, w_wr_log, w_rd_log;
   logic [LOG_N_MAX-1:0] w_rev, w_wr_addr, w_wr_max, w_rd_max;
   logic [1:0]           w_set, w_clr;
   logic                 w_wr, w_rd, w_wr_done, w_rd_done, w_out_valid;
   assign w_flog_in = (io_s.frame_log > 3'(LOG_N_MAX)) ? L_MAX : FW'(io_s.frame_log);
   // the first beat of a frame already uses the freshly sampled length
   assign w_wr_log  = (r_wr_cnt == '0) ? w_flog_in : r_flog[r_wr_sel];
   assign w_rd_log  = r_flog[r_rd_sel];
   assign w_wr_max  = ONES >> (L_MAX - w_wr_log);
   assign w_rd_max  = ONES >> (L_MAX - w_rd_log);
   for (genvar i = 0; i < LOG_N_MAX; i++) begin : g_rev
      assign w_rev[i] = r_wr_cnt[LOG_N_MAX-1-i];
   end
   // full-width reversal shifted down leaves an L-bit reversal with zero upper bits
   assign w_wr_addr = w_rev >> (L_MAX - w_wr_log);
   assign w_out_valid    = r_full[r_rd_sel];
   assign io_s.in_ready  = ~rst & ~r_full[r_wr_sel];
   assign io_s.out_valid = w_out_valid;
   assign io_s.out_data  = w_out_valid ? r_mem[r_rd_sel][r_rd_cnt] : '0;
   assign io_s.out_last  = w_out_valid & (r_rd_cnt == w_rd_max);
   assign w_wr      = io_s.in_valid & ~rst & ~r_full[r_wr_sel];
   assign w_rd      = w_out_valid & io_s.out_ready;
   assign w_wr_done = w_wr & (r_wr_cnt == w_wr_max);
   assign w_rd_done = w_rd & (r_rd_cnt == w_rd_max);
   assign w_set     = {w_wr_done & r_wr_sel, w_wr_done & ~r_wr_sel};
   assign w_clr     = {w_rd_done & r_rd_sel, w_rd_done & ~r_rd_sel};
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full    <= '0;
         r_wr_sel  <= 1'b0;
         r_rd_sel  <= 1'b0;
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
         r_flog[0] <= '0;
         r_flog[1] <= '0;
      end else begin
         if (w_wr && r_wr_cnt == '0) r_flog[r_wr_sel] <= w_flog_in;
         if (w_wr) r_wr_cnt <= w_wr_done ? '0 : r_wr_cnt + LOG_N_MAX'(1);
         if (w_wr_done) r_wr_sel <= ~r_wr_sel;
         if (w_rd) r_rd_cnt <= w_rd_done ? '0 : r_rd_cnt + LOG_N_MAX'(1);
         if (w_rd_done) r_rd_sel <= ~r_rd_sel;
         r_full <= (r_full | w_set) & ~w_clr;
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_sel][w_wr_addr] <= io_s.in_data;
   end
endmodule

// File: doc/bitrev_reorder_buf.md
# bitrev_reorder_buf

Ping-pong reorder buffer on the NTT output path. It accepts coefficients that arrive in bit-reversed index order and streams them out in natural index order. Frame length is chosen at run time as 2^frame_log. Both sides use a valid/ready handshake. It is the consumer-side counterpart of the bit-reverse index generator: it undoes the bit-reversed ordering that the generator produces.

## Interface
- DATA_W, 64: coefficient width in bits.
- LOG_N_MAX, 6: log2 of the maximum frame length; each bank holds 2^LOG_N_MAX words.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- frame_log  in  3  log2 of the frame length N. Sampled on the first accepted beat of each frame; values above LOG_N_MAX clamp to LOG_N_MAX.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DATA_W  coefficient; beat k of a frame carries element bitrev(k).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  coefficient in natural order; 0 when out_valid=0.
- out_last  out  1  marks the final beat of a frame (index N-1).

## Operation
- Storage: two banks (bank 0 and bank 1) of 2^LOG_N_MAX × DATA_W flops.
- Per-bank state: full flag and latched length code flog[b].
- Pointers: wr_sel, rd_sel, wr_cnt and rd_cnt, each counter LOG_N_MAX bits wide.
- Write side:
  - in_ready = ~rst & ~full[wr_sel].
  - On accept with wr_cnt=0: latch flog[wr_sel] from clamped frame_log.
  - Each accepted beat writes to address rev(wr_cnt, L), where L is the latched length code. rev reverses bits [L-1:0] of the count; bits at position L and above are 0.
  - On accept with wr_cnt=N-1: set full[wr_sel], clear wr_cnt, toggle wr_sel. Otherwise wr_cnt increments.
- Read side:
  - out_valid = full[rd_sel].
  - out_data = bank[rd_sel][rd_cnt].
  - out_last = out_valid & (rd_cnt = N_rd-1), where N_rd = 2^flog[rd_sel].
  - On accept with rd_cnt=N_rd-1: clear full[rd_sel], clear rd_cnt, toggle rd_sel. Otherwise rd_cnt increments.
- frame_log=0: N=1, each single beat is a complete frame, and out_last is asserted on every beat.
- frame_log changes in the middle of a frame are ignored until the next frame starts.
- Simultaneous events:
  - The write completing on one bank and the read completing on the other bank in the same cycle both take effect.
  - Set and clear never target the same bank in the same cycle, because writes require ~full and reads require full.

## Timing
- Reset values, held while rst=1:
  - full = 00, wr_sel = rd_sel = 0, counters = 0, flog = 0.
  - in_ready = 0, out_valid = 0, out_data = 0, out_last = 0.
- First cycle after reset release: in_ready = 1.
- rst asserted mid-frame discards all buffered and partial frames with no output.
- Latency: out_valid rises in the cycle after the N-th input beat is accepted. out_data for index 0 is valid in that same cycle.
- Throughput: with in_valid and out_ready held high, one beat per cycle sustained on both sides across frames. The ping-pong banks hide the fill and drain overlap.
- Bank release: a bank freed by the final read is writable in the next cycle (full is registered), with no further delay.
- Backpressure:
  - Both buffers full gives in_ready=0 until the reader completes a frame.
  - out_ready=0 holds out_data and out_last stable.

## Test plan
- Basic reorder:
  - Stimulus: frame_log=3, input data 0,4,2,6,1,5,3,7 back-to-back.
  - Required: out_valid asserted 1 cycle after the last beat; output 0..7 in order; out_last on the value 7 only.
- Sustained rate:
  - Stimulus: 4 consecutive N=16 frames with in_valid and out_ready tied high, data = bitrev4(k)+16·f.
  - Required: 64 outputs 0..63 with no bubbles after the first frame; in_ready never deasserts.
- Backpressure:
  - Stimulus: N=8, out_ready=0 while 2 frames load.
  - Required: in_ready drops after the 16th beat. After out_ready rises, in_ready returns 1 cycle after the 8th output.
- Length change between frames:
  - Stimulus: frame of N=4 (0,2,1,3), then N=2 (10,11), then frame_log switched to 5 in the middle of the N=2 frame.
  - Required: output 0,1,2,3 then 10,11; out_last on 3 and on 11.
- Degenerate and clamp:
  - Stimulus: frame_log=0 with 3 single beats; then frame_log=7 with LOG_N_MAX=6.
  - Required: each single beat is echoed with out_last=1. The clamped frame has 64 beats and is reordered by 6-bit bit reversal.
- Reset mid-operation:
  - Stimulus: assert rst after 5 beats of an N=8 frame, then send a fresh N=8 frame.
  - Required: outputs are all-zero and invalid during rst; only the fresh frame appears, correctly reordered.
